idex_pipe_reg: RTL and testbench
================================

Name: idex_pipe_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline; it is the consumer of the load-use stall controls (IDEX_WriteEn, Stall_flush) and of branch flush.
- Holds, loads or bubbles the decoded instruction, and feeds EX_MemRead/EX_rt back to the stall unit to close the hazard loop.
- Also keeps a saturating bubble counter and a stall-streak watchdog, so a stall that never releases is flagged.

Parameters:
- DATA_W, 32, width of PC+4, register-read and immediate fields
- CTRL_W, 10, control bundle width {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], Jump}
- CNT_W, 16, bubble counter width
- MAX_STALL, 1, max consecutive Stall_flush cycles before Stall_err

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- IDEX_WriteEn  in  1  load enable from the stall unit (0 = hold)
- Stall_flush  in  1  insert bubble (load-use)
- Branch_flush  in  1  squash the ID instruction (taken branch/jump)
- ID_PC4  in  DATA_W  PC+4 of the ID instruction
- ID_ReadData1  in  DATA_W  rs data
- ID_ReadData2  in  DATA_W  rt data
- ID_Imm  in  DATA_W  sign-extended immediate
- ID_rs, ID_rt, ID_rd  in  5 each  register specifiers
- ID_Ctrl  in  CTRL_W  decoded control bundle
- EX_PC4, EX_ReadData1, EX_ReadData2, EX_Imm  out  DATA_W  registered data
- EX_rs, EX_rt, EX_rd  out  5 each  registered specifiers
- EX_Ctrl  out  CTRL_W  registered control (all zero = bubble)
- EX_MemRead  out  1  equals EX_Ctrl[MEMREAD]; feeds back to the stall unit
- EX_valid  out  1  1 = real instruction in EX
- Bubble_count  out  CNT_W  saturating count of bubbles inserted
- Stall_err  out  1  sticky; streak exceeded MAX_STALL

Behaviour:
- Reset (async, immediate):
  - all data, specifier and control outputs go to 0.
  - EX_valid=0, Bubble_count=0, Stall_err=0, internal streak=0.
- On each rising clk edge, one action is taken, in this priority order:
  - (1) Branch_flush=1: EX_Ctrl<=0, EX_valid<=0. Data and specifier regs load the ID values; this is harmless because control is 0. Bubble_count increments.
  - (2) else Stall_flush=1: EX_Ctrl<=0, EX_valid<=0. Data and specifiers hold, even though IDEX_WriteEn=0 accompanies it. Bubble_count increments.
  - (3) else IDEX_WriteEn=0: every register holds, including EX_valid. No count.
  - (4) else: all fields load from ID; EX_valid<=1.
- Latency: one cycle, ID inputs to EX outputs.
- EX_MemRead is a pure wire of EX_Ctrl bit MEMREAD. Because a bubble clears it, the stall unit sees EX_MemRead=0 on the cycle after the bubble, and the stall releases after exactly one cycle.
- Bubble_count: increments by 1 per bubble cycle and saturates at 2^CNT_W-1; no wrap.
- Stall streak counter:
  - increments on each cycle with Stall_flush=1 and Branch_flush=0; clears to 0 on any other cycle.
  - Stall_err sets when the streak would exceed MAX_STALL, i.e. the (MAX_STALL+1)th consecutive stall edge.
  - Stall_err stays set until reset.
  - The streak counter saturates; its width is clog2(MAX_STALL+2).
- Simultaneous events:
  - Branch_flush and Stall_flush together: the branch action applies and the streak clears.
  - Stall_flush=1 with IDEX_WriteEn=1: bubble, same as case (2).
- Reset asserted mid-stall: everything clears at once. After deassertion the first edge obeys the inputs normally.
- No combinational path from any input to any output.

Decomposition:
- Shared package pipe_pkg:
  - control bit index constants (CTRL_REGDST … CTRL_JUMP, CTRL_MEMREAD=5)
  - CTRL_W
  - the all-zero bubble constant CTRL_NOP
- Sub-module sat_counter (parameter W): inc, clr and async reset; outputs count. It is instantiated twice, for Bubble_count and for the stall streak.

Test Plan:
- Reset: reset=1 mid-operation with EX_Ctrl=10'h3FF → all outputs 0 at once, before any clock edge; Bubble_count=0.
- Normal flow: IDEX_WriteEn=1, ID_Ctrl=10'h0A4, ID_rt=5'd8, ID_Imm=32'h0000_0010 → next edge EX_Ctrl=10'h0A4, EX_rt=8, EX_valid=1.
- Load-use: lw (MemRead=1, EX_rt=9) in EX; the next instruction uses rs=9, with WriteEn=0 and Stall_flush=1 for one edge → EX_Ctrl=0, EX_valid=0, EX_rt stays 9, EX_MemRead=0, Bubble_count=1. The next edge loads the dependent instruction with EX_valid=1.
- Branch squash: Branch_flush=1 together with Stall_flush=1 → bubble, Bubble_count+1, streak=0, Stall_err=0.
- Watchdog: Stall_flush held for 2 edges with MAX_STALL=1 → Stall_err=1 after the 2nd edge. Stall_err stays 1 after Stall_flush drops, and clears only on reset.
- Saturation: CNT_W=4, 20 bubble cycles → Bubble_count=15 and holds there.

Source files
------------

// File: rtl/idex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle layout,
// the bubble constant and the per-edge action selection.
package pipe_pkg;

  localparam int CTRL_W = 10;

  // Control bundle, MSB first: {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead,
  // MemWrite, Branch, ALUOp[1:0], Jump}
  localparam int CTRL_REGDST   = 9;
  localparam int CTRL_ALUSRC   = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_JUMP     = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_LOAD   = 2'd3
  } idex_action_e;

  function automatic idex_action_e pick_action(input logic branch_flush,
                                               input logic stall_flush,
                                               input logic write_en);
    idex_action_e act;
    if (branch_flush) begin
      act = ACT_FLUSH;
    end else if (stall_flush) begin
      act = ACT_BUBBLE;
    end else if (!write_en) begin
      act = ACT_HOLD;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

endpackage

// File: rtl/idex_pipe_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register; master drives the
// decoded instruction and stall controls, slave is the register itself.
interface idex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();

  logic                  IDEX_WriteEn;
  logic                  Stall_flush;
  logic                  Branch_flush;
  logic [DATA_W-1:0]     ID_PC4;
  logic [DATA_W-1:0]     ID_ReadData1;
  logic [DATA_W-1:0]     ID_ReadData2;
  logic [DATA_W-1:0]     ID_Imm;
  logic [4:0]            ID_rs;
  logic [4:0]            ID_rt;
  logic [4:0]            ID_rd;
  pipe_pkg::ctrl_t       ID_Ctrl;

  logic [DATA_W-1:0]     EX_PC4;
  logic [DATA_W-1:0]     EX_ReadData1;
  logic [DATA_W-1:0]     EX_ReadData2;
  logic [DATA_W-1:0]     EX_Imm;
  logic [4:0]            EX_rs;
  logic [4:0]            EX_rt;
  logic [4:0]            EX_rd;
  pipe_pkg::ctrl_t       EX_Ctrl;
  logic                  EX_MemRead;
  logic                  EX_valid;
  logic [CNT_W-1:0]      Bubble_count;
  logic                  Stall_err;

  modport master (
    output IDEX_WriteEn, Stall_flush, Branch_flush,
    output ID_PC4, ID_ReadData1, ID_ReadData2, ID_Imm, ID_rs, ID_rt, ID_rd, ID_Ctrl,
    input  EX_PC4, EX_ReadData1, EX_ReadData2, EX_Imm, EX_rs, EX_rt, EX_rd, EX_Ctrl,
    input  EX_MemRead, EX_valid, Bubble_count, Stall_err
  );

  modport slave (
    input  IDEX_WriteEn, Stall_flush, Branch_flush,
    input  ID_PC4, ID_ReadData1, ID_ReadData2, ID_Imm, ID_rs, ID_rt, ID_rd, ID_Ctrl,
    output EX_PC4, EX_ReadData1, EX_ReadData2, EX_Imm, EX_rs, EX_rt, EX_rd, EX_Ctrl,
    output EX_MemRead, EX_valid, Bubble_count, Stall_err
  );

endinterface

// File: rtl/idex_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-high reset.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] COUNT_MAX = '1;

  // Count up on inc, stick at all-ones, return to zero on clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: loads, holds or bubbles the decoded instruction,
// counts inserted bubbles and flags a stall streak that never releases.
module idex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 1
) (
  input logic           clk,
  input logic           reset,
  idex_pipe_reg_if.slave bus
);

  localparam int STREAK_W = $clog2(MAX_STALL + 2);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STALL);

  logic [DATA_W-1:0]   pc4;
  logic [DATA_W-1:0]   read_data1;
  logic [DATA_W-1:0]   read_data2;
  logic [DATA_W-1:0]   imm;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  ctrl_t               ctrl;
  logic                valid;
  logic                stall_err;
  logic [CNT_W-1:0]    bubble_count;
  logic [STREAK_W-1:0] streak;

  idex_action_e action;
  logic         bubble_inc;
  logic         stall_edge;

  // Decode this edge's action and the counter controls
  always_comb begin
    action     = pick_action(bus.Branch_flush, bus.Stall_flush, bus.IDEX_WriteEn);
    bubble_inc = 1'b0;
    stall_edge = 1'b0;
    case (action)
      ACT_FLUSH:  bubble_inc = 1'b1;
      ACT_BUBBLE: begin
        bubble_inc = 1'b1;
        stall_edge = 1'b1;
      end
      ACT_HOLD:   bubble_inc = 1'b0;
      ACT_LOAD:   bubble_inc = 1'b0;
      default:    bubble_inc = 1'b0;
    endcase
  end

  // Pipeline fields: a squashed instruction still loads its data, control is zeroed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc4        <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      imm        <= '0;
      rs         <= '0;
      rt         <= '0;
      rd         <= '0;
      ctrl       <= CTRL_NOP;
      valid      <= 1'b0;
    end else begin
      case (action)
        ACT_FLUSH, ACT_LOAD: begin
          pc4        <= bus.ID_PC4;
          read_data1 <= bus.ID_ReadData1;
          read_data2 <= bus.ID_ReadData2;
          imm        <= bus.ID_Imm;
          rs         <= bus.ID_rs;
          rt         <= bus.ID_rt;
          rd         <= bus.ID_rd;
          ctrl       <= (action == ACT_LOAD) ? bus.ID_Ctrl : CTRL_NOP;
          valid      <= (action == ACT_LOAD);
        end
        ACT_BUBBLE: begin
          ctrl  <= CTRL_NOP;
          valid <= 1'b0;
        end
        default: begin
          ctrl  <= ctrl;
          valid <= valid;
        end
      endcase
    end
  end

  // Sticky watchdog: trips on the stall edge that would push the streak past the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_err <= 1'b0;
    end else if (stall_edge && (streak >= STREAK_LIMIT)) begin
      stall_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .clr   (1'b0),
    .count (bubble_count)
  );

  sat_counter #(.W(STREAK_W)) u_streak_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_edge),
    .clr   (~stall_edge),
    .count (streak)
  );

  assign bus.EX_PC4       = pc4;
  assign bus.EX_ReadData1 = read_data1;
  assign bus.EX_ReadData2 = read_data2;
  assign bus.EX_Imm       = imm;
  assign bus.EX_rs        = rs;
  assign bus.EX_rt        = rt;
  assign bus.EX_rd        = rd;
  assign bus.EX_Ctrl      = ctrl;
  assign bus.EX_MemRead   = ctrl[CTRL_MEMREAD];
  assign bus.EX_valid     = valid;
  assign bus.Bubble_count = bubble_count;
  assign bus.Stall_err    = stall_err;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Bench for idex_pipe_reg: directed vector table, hand-written reset/watchdog/
// saturation sequences and random traffic against an instruction-level model.
module tb_idex_pipe_reg;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  idex_pipe_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  idex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what instruction sits in EX, plus counters as integers
  typedef struct {
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [9:0]  ctrl;
    logic        valid;
  } ex_t;

  ex_t  m_ex;
  int   m_bubbles;
  int   m_streak;
  logic m_err;

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ex      = '{pc4: 32'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0,
                  rs: 5'd0, rt: 5'd0, rd: 5'd0, ctrl: 10'd0, valid: 1'b0};
    m_bubbles = 0;
    m_streak  = 0;
    m_err     = 1'b0;
  endtask

  task automatic model_edge();
    ex_t id;
    id = '{pc4: bus.ID_PC4, rd1: bus.ID_ReadData1, rd2: bus.ID_ReadData2, imm: bus.ID_Imm,
           rs: bus.ID_rs, rt: bus.ID_rt, rd: bus.ID_rd, ctrl: bus.ID_Ctrl, valid: 1'b1};
    if (bus.Branch_flush) begin
      m_ex       = id;
      m_ex.ctrl  = 10'd0;
      m_ex.valid = 1'b0;
      m_bubbles++;
    end else if (bus.Stall_flush) begin
      m_ex.ctrl  = 10'd0;
      m_ex.valid = 1'b0;
      m_bubbles++;
    end else if (bus.IDEX_WriteEn) begin
      m_ex = id;
    end
    if (m_bubbles > CNT_MAX) m_bubbles = CNT_MAX;
    m_streak = (bus.Stall_flush && !bus.Branch_flush) ? m_streak + 1 : 0;
    if (m_streak > MAX_STALL) m_err = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc4"},     64'(bus.EX_PC4),       64'(m_ex.pc4));
    chk({tag, ".rd1"},     64'(bus.EX_ReadData1), 64'(m_ex.rd1));
    chk({tag, ".rd2"},     64'(bus.EX_ReadData2), 64'(m_ex.rd2));
    chk({tag, ".imm"},     64'(bus.EX_Imm),       64'(m_ex.imm));
    chk({tag, ".rs"},      64'(bus.EX_rs),        64'(m_ex.rs));
    chk({tag, ".rt"},      64'(bus.EX_rt),        64'(m_ex.rt));
    chk({tag, ".rd"},      64'(bus.EX_rd),        64'(m_ex.rd));
    chk({tag, ".ctrl"},    64'(bus.EX_Ctrl),      64'(m_ex.ctrl));
    chk({tag, ".memread"}, 64'(bus.EX_MemRead),   64'(m_ex.ctrl[5]));
    chk({tag, ".valid"},   64'(bus.EX_valid),     64'(m_ex.valid));
    chk({tag, ".bubbles"}, 64'(bus.Bubble_count), 64'(m_bubbles));
    chk({tag, ".err"},     64'(bus.Stall_err),    64'(m_err));
  endtask

  task automatic drive(input logic we, input logic sf, input logic bf, input logic [9:0] ctrl,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm);
    bus.IDEX_WriteEn = we;
    bus.Stall_flush  = sf;
    bus.Branch_flush = bf;
    bus.ID_Ctrl      = ctrl;
    bus.ID_rs        = rs;
    bus.ID_rt        = rt;
    bus.ID_rd        = rd;
    bus.ID_PC4       = pc4;
    bus.ID_ReadData1 = rd1;
    bus.ID_ReadData2 = rd2;
    bus.ID_Imm       = imm;
  endtask

  // Apply current inputs across one rising edge, then compare against the model
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Assert reset between edges and check that everything clears before the next edge
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       we, sf, bf;
    logic [9:0] ctrl;
    logic [4:0] rt;
    logic [9:0] e_ctrl;
    logic [4:0] e_rt;
    logic       e_valid, e_mr;
    int         e_bub;
    logic       e_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 10'h000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    model_reset();
    #12;
    check_model("por");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-operation with a fully set control bundle in EX
    drive(1'b1, 1'b0, 1'b0, 10'h3FF, 5'd1, 5'd2, 5'd3, 32'h104, 32'hAA, 32'hBB, 32'hCC);
    step("load3ff");
    chk("pre_reset.ctrl", 64'(bus.EX_Ctrl), 64'h3FF);
    async_reset("rst_mid");

    // Directed table: lw, load-use bubble, hold, branch squash, watchdog trip
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'h0A4, 5'd9,  10'h0A4, 5'd9,  1'b1, 1'b1, 0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 10'h0A4, 5'd5,  10'h000, 5'd9,  1'b0, 1'b0, 1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'h240, 5'd3,  10'h240, 5'd3,  1'b1, 1'b0, 1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'h3FF, 5'd7,  10'h240, 5'd3,  1'b1, 1'b0, 1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 10'h3FF, 5'd12, 10'h000, 5'd12, 1'b0, 1'b0, 2, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 10'h000, 5'd1,  10'h000, 5'd12, 1'b0, 1'b0, 3, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 10'h0A4, 5'd8,  10'h0A4, 5'd8,  1'b1, 1'b1, 3, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 10'h000, 5'd6,  10'h0A4, 5'd8,  1'b1, 1'b1, 3, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 10'h0A4, 5'd4,  10'h000, 5'd8,  1'b0, 1'b0, 4, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 10'h3FF, 5'd2,  10'h000, 5'd8,  1'b0, 1'b0, 5, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 10'h011, 5'd4,  10'h011, 5'd4,  1'b1, 1'b0, 5, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 10'h000, 5'd0,  10'h011, 5'd4,  1'b1, 1'b0, 5, 1'b1};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].we, vecs[i].sf, vecs[i].bf, vecs[i].ctrl, 5'(i), vecs[i].rt, 5'(i + 1),
            32'h400 + 32'(i * 4), 32'(i * 3), 32'(i * 5), 32'(vecs[i].rt) << 4);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.ctrl", i),  64'(bus.EX_Ctrl),      64'(vecs[i].e_ctrl));
      chk($sformatf("vec%0d.rt", i),    64'(bus.EX_rt),        64'(vecs[i].e_rt));
      chk($sformatf("vec%0d.imm", i),   64'(bus.EX_Imm),       64'(vecs[i].e_rt) << 4);
      chk($sformatf("vec%0d.valid", i), 64'(bus.EX_valid),     64'(vecs[i].e_valid));
      chk($sformatf("vec%0d.mr", i),    64'(bus.EX_MemRead),   64'(vecs[i].e_mr));
      chk($sformatf("vec%0d.bub", i),   64'(bus.Bubble_count), 64'(vecs[i].e_bub));
      chk($sformatf("vec%0d.err", i),   64'(bus.Stall_err),    64'(vecs[i].e_err));
    end

    // Sticky error clears only on reset
    async_reset("rst_err");
    chk("err_cleared", 64'(bus.Stall_err), 64'd0);

    // Reset in the middle of a stall streak: the streak must restart from zero
    drive(1'b0, 1'b1, 1'b0, 10'h0A4, 5'd1, 5'd9, 5'd2, 32'h10, 32'h11, 32'h12, 32'h13);
    step("pre_rst_stall");
    async_reset("rst_stall");
    step("post_rst_stall");
    chk("streak_restart.err", 64'(bus.Stall_err), 64'd0);
    chk("streak_restart.bub", 64'(bus.Bubble_count), 64'd1);
    async_reset("rst_sat");

    // Saturation: 20 branch bubbles with a 4-bit counter
    drive(1'b1, 1'b0, 1'b1, 10'h3FF, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i));
      if (i == 14) chk("sat_reached", 64'(bus.Bubble_count), 64'd15);
    end
    chk("sat_hold", 64'(bus.Bubble_count), 64'd15);
    chk("sat_noerr", 64'(bus.Stall_err), 64'd0);
    async_reset("rst_rand");

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0, 10'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom);
      step($sformatf("rnd%0d", i));
      if ((i % 97) == 96) async_reset($sformatf("rnd_rst%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
